// File: rtl/ntt_basemul_if.sv
// rtl/ntt_basemul_if.sv - start/done handshake and operand/result arrays of the Kyber base-case multiplier (NTT_BASEMUL_ACCUM_EN adds accumulate)
interface ntt_basemul_if #(
  parameter int N = 256
);
  logic              start;
  logic              busy;
  logic              done;
  logic signed [31:0] a [N];
  logic signed [31:0] b [N];
  logic signed [31:0] h [N];
`ifdef NTT_BASEMUL_ACCUM_EN
  logic              accumulate;

  modport master (output start, a, b, accumulate, input busy, done, h);
  modport slave  (input start, a, b, accumulate, output busy, done, h);
`else
  modport master (output start, a, b, input busy, done, h);
  modport slave  (input start, a, b, output busy, done, h);
`endif
endinterface

// File: rtl/ntt_basemul.sv
// rtl/ntt_basemul.sv - Kyber NTT-domain pointwise multiply mod X^2-gamma_i, one pair per 3 cycles (NTT_BASEMUL_ACCUM_EN adds h += a*b)
module ntt_basemul #(
  parameter int N = 256,
  parameter int Q = 3329
) (
  input logic         clk,
  input logic         rst,
  ntt_basemul_if.slave bus
);

  localparam int P  = N / 2;
  localparam int PW = $clog2(P);
  localparam logic signed [31:0] QS = 32'(Q);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PROD, S_GAMMA, S_WRITE, S_DONE} state_t;

  // gamma[k] = 17^(2*bitrev(k)+1) mod Q, evaluated at elaboration time only
  function automatic logic [15:0] gamma_calc(input int k);
    int     br;
    longint acc;
    br = 0;
    for (int j = 0; j < PW; j++) begin
      if (k[j]) br = br | (1 << (PW - 1 - j));
    end
    acc = 1;
    for (int n = 0; n < 2 * br + 1; n++) acc = (acc * 17) % Q;
    return 16'(acc);
  endfunction

  logic [15:0] gamma_rom [P];
  for (genvar gi = 0; gi < P; gi++) begin : g_rom
    localparam logic [15:0] GV = gamma_calc(gi);
    assign gamma_rom[gi] = GV;
  end

  state_t             state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  logic signed [31:0] a_q [N];
  logic signed [31:0] a_d [N];
  logic signed [31:0] b_q [N];
  logic signed [31:0] b_d [N];
  logic signed [31:0] h_q [N];
  logic signed [31:0] h_d [N];
  logic signed [31:0] r00_q, r00_d, r11_q, r11_d, r01_q, r01_d, r10_q, r10_d;
  logic signed [31:0] t_q, t_d, s1_q, s1_d;
`ifdef NTT_BASEMUL_ACCUM_EN
  logic               acc_q, acc_d;
`endif

  logic [PW:0]        ie, io;
  logic signed [31:0] g_s;

  // next-state, operand capture and per-pair datapath
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;
    h_d     = h_q;
    r00_d   = r00_q;
    r11_d   = r11_q;
    r01_d   = r01_q;
    r10_d   = r10_q;
    t_d     = t_q;
    s1_d    = s1_q;
`ifdef NTT_BASEMUL_ACCUM_EN
    acc_d   = acc_q;
`endif
    ie  = {p_q, 1'b0};
    io  = {p_q, 1'b1};
    g_s = $signed({16'd0, gamma_rom[p_q]});
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        a_d = bus.a;
        b_d = bus.b;
`ifdef NTT_BASEMUL_ACCUM_EN
        acc_d = bus.accumulate;
`endif
        p_d     = '0;
        state_d = S_PROD;
      end
      S_PROD: begin
        r00_d   = a_q[ie] * b_q[ie];
        r11_d   = a_q[io] * b_q[io];
        r01_d   = a_q[ie] * b_q[io];
        r10_d   = a_q[io] * b_q[ie];
        state_d = S_GAMMA;
      end
      S_GAMMA: begin
        // reduce a1*b1 first so the gamma product stays below 2^24
        t_d     = ((r11_q % QS) * g_s) % QS;
        s1_d    = (r01_q + r10_q) % QS;
        state_d = S_WRITE;
      end
      S_WRITE: begin
`ifdef NTT_BASEMUL_ACCUM_EN
        if (acc_q) begin
          h_d[ie] = (h_q[ie] + r00_q + t_q) % QS;
          h_d[io] = (h_q[io] + s1_q) % QS;
        end else begin
          h_d[ie] = (r00_q + t_q) % QS;
          h_d[io] = s1_q;
        end
`else
        h_d[ie] = (r00_q + t_q) % QS;
        h_d[io] = s1_q;
`endif
        if (p_q == PW'(P - 1)) begin
          p_d     = '0;
          state_d = S_DONE;
        end else begin
          p_d     = p_q + PW'(1);
          state_d = S_PROD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers; reset abandons any run in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      h_q     <= '{default: '0};
      r00_q   <= '0;
      r11_q   <= '0;
      r01_q   <= '0;
      r10_q   <= '0;
      t_q     <= '0;
      s1_q    <= '0;
`ifdef NTT_BASEMUL_ACCUM_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
      h_q     <= h_d;
      r00_q   <= r00_d;
      r11_q   <= r11_d;
      r01_q   <= r01_d;
      r10_q   <= r10_d;
      t_q     <= t_d;
      s1_q    <= s1_d;
`ifdef NTT_BASEMUL_ACCUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.h    = h_q;

endmodule

// File: tb/tb_ntt_basemul.sv
// tb/tb_ntt_basemul.sv - scoreboard bench for ntt_basemul against a polynomial-ring reference model
module tb_ntt_basemul;
  localparam int N = 256;
  localparam int Q = 3329;
  localparam int P = N / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ntt_basemul_if #(.N(N)) bus();
  ntt_basemul #(.N(N), .Q(Q)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ta   [N];
  int tbv  [N];
  int prev [N];
  int exp_mem [8][N];
  int exp_q [$];
  int slot = 0;

  function automatic int ref_gamma(input int i);
    int     br;
    int     e;
    longint base;
    longint res;
    br = 0;
    for (int j = 0; j < 7; j++) if (i[j]) br = br + (1 << (6 - j));
    e = 2 * br + 1;
    base = 17;
    res = 1;
    while (e > 0) begin
      if (e % 2 == 1) res = (res * base) % Q;
      base = (base * base) % Q;
      e = e / 2;
    end
    return int'(res);
  endfunction

  // (a0 + a1 X)(b0 + b1 X) mod (X^2 - gamma), optionally added to the previous result
  function automatic void push_expected(input bit acc);
    longint a0, a1, b0, b1, g, e0, e1;
    for (int i = 0; i < P; i++) begin
      a0 = ta[2*i];  a1 = ta[2*i+1];
      b0 = tbv[2*i]; b1 = tbv[2*i+1];
      g  = ref_gamma(i);
      e0 = (a0 * b0 + a1 * b1 * g) % Q;
      e1 = (a0 * b1 + a1 * b0) % Q;
      if (acc) begin
        e0 = (e0 + prev[2*i]) % Q;
        e1 = (e1 + prev[2*i+1]) % Q;
      end
      exp_mem[slot][2*i]   = int'(e0);
      exp_mem[slot][2*i+1] = int'(e1);
      prev[2*i]   = int'(e0);
      prev[2*i+1] = int'(e1);
    end
    exp_q.push_back(slot);
    slot = (slot + 1) % 8;
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_ops();
    for (int i = 0; i < N; i++) begin
      ta[i] = 0;
      tbv[i] = 0;
    end
  endtask

  task automatic random_ops();
    for (int i = 0; i < N; i++) begin
      ta[i]  = int'($urandom_range(Q - 1, 0));
      tbv[i] = int'($urandom_range(Q - 1, 0));
    end
  endtask

  task automatic drive_ops(input bit acc);
    for (int i = 0; i < N; i++) begin
      bus.a[i] = ta[i];
      bus.b[i] = tbv[i];
    end
`ifdef NTT_BASEMUL_ACCUM_EN
    bus.accumulate = acc;
`else
    if (acc) $display("accumulate ignored in this build");
`endif
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      bus.a[i] = int'($urandom_range(Q - 1, 0));
      bus.b[i] = int'($urandom_range(Q - 1, 0));
    end
`ifdef NTT_BASEMUL_ACCUM_EN
    bus.accumulate = ~bus.accumulate;
`endif
  endtask

  task automatic run_case(input bit acc, input bit scramble, input bit mid_start, input string name);
    int cnt;
    bit busy_bad;
    @(negedge clk);
    drive_ops(acc);
    push_expected(acc);
    bus.start = 1'b1;
    @(posedge clk);
    cnt = 1;
    busy_bad = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && cnt < 600) begin
      if (!bus.busy) busy_bad = 1'b1;
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (scramble && cnt == 2) scramble_inputs();
      if (mid_start && cnt == 60) bus.start = 1'b1;
      if (mid_start && cnt == 62) bus.start = 1'b0;
    end
    if (!bus.busy) busy_bad = 1'b1;
    check({name, "_latency"}, cnt, 386);
    check({name, "_busy_during_run"}, busy_bad, 0);
    @(negedge clk);
    check({name, "_busy_after_done"}, bus.busy, 0);
  endtask

  // scoreboard monitor: every done pulse consumes one expected result
  initial begin
    int s, nbad, first;
    forever begin
      @(negedge clk);
      if (!rst && bus.done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got done=1 want no done");
        end else begin
          s = exp_q.pop_front();
          nbad = 0;
          first = -1;
          for (int i = 0; i < N; i++) begin
            if (bus.h[i] !== exp_mem[s][i]) begin
              nbad++;
              if (first < 0) first = i;
            end
          end
          if (nbad != 0) begin
            bad++;
            $display("FAIL h_result: %0d wrong coefficients, h[%0d] got %0d want %0d",
                     nbad, first, bus.h[first], exp_mem[s][first]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nz, cnt, gap, idle;
    bus.start = 1'b0;
    clear_ops();
    for (int i = 0; i < N; i++) prev[i] = 0;
    drive_ops(1'b0);
    repeat (3) @(negedge clk);
    nz = 0;
    for (int i = 0; i < N; i++) if (bus.h[i] != 0) nz++;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_h_nonzero", nz, 0);
    rst = 1'b0;

    clear_ops();
    run_case(1'b0, 1'b0, 1'b0, "zeros");

    clear_ops();
    ta[0] = 1; tbv[0] = 5; tbv[1] = 7;
    run_case(1'b0, 1'b0, 1'b0, "unit");

    clear_ops();
    ta[1] = 1; ta[3] = 1; tbv[1] = 1; tbv[3] = 1;
    run_case(1'b0, 1'b0, 1'b0, "gamma");

    for (int i = 0; i < N; i++) begin
      ta[i] = Q - 1;
      tbv[i] = Q - 1;
    end
    run_case(1'b0, 1'b0, 1'b0, "max");

    for (int r = 0; r < 3; r++) begin
      random_ops();
      run_case(1'b0, 1'b1, 1'b1, "random");
    end

    // reset 100 cycles into a run
    random_ops();
    @(negedge clk);
    drive_ops(1'b0);
    push_expected(1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    for (int i = 0; i < N; i++) prev[i] = 0;
    #1;
    nz = 0;
    for (int i = 0; i < N; i++) if (bus.h[i] != 0) nz++;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_h_nonzero", nz, 0);
    repeat (3) @(negedge clk);
    check("midrst_done_held", bus.done, 0);
    rst = 1'b0;
    clear_ops();
    ta[0] = 1; tbv[0] = 5; tbv[1] = 7;
    run_case(1'b0, 1'b0, 1'b0, "after_rst");

    // start held high: back-to-back runs with a single idle cycle between
    random_ops();
    @(negedge clk);
    drive_ops(1'b0);
    push_expected(1'b0);
    push_expected(1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    while (!bus.done && cnt < 600) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check("held_first_latency", cnt, 386);
    gap = 0;
    idle = 0;
    do begin
      @(posedge clk);
      gap++;
      @(negedge clk);
      if (!bus.busy) idle++;
    end while (!bus.done && gap < 800);
    bus.start = 1'b0;
    check("held_gap", gap, 387);
    check("held_idle_cycles", idle, 1);
    @(negedge clk);
    check("held_busy_after", bus.busy, 0);

`ifdef NTT_BASEMUL_ACCUM_EN
    clear_ops();
    ta[0] = 1; tbv[0] = 5; tbv[1] = 7;
    run_case(1'b0, 1'b0, 1'b0, "acc_off");
    run_case(1'b1, 1'b0, 1'b0, "acc_on");
    random_ops();
    run_case(1'b1, 1'b1, 1'b0, "acc_random");
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntt_basemul.md
Name: ntt_basemul

Overview:
- Pointwise base-case multiplier of two Kyber polynomials, both in the NTT domain.
- Computes h = a ∘ b over 128 degree-1 pairs modulo X^2 − gamma_i.
- Sits directly upstream of the inverse NTT: its h array and done pulse drive that block's f input and start.
- Sequential: one pair per 3 cycles, with start/done handshake.

Parameters:
- N, 256, polynomial length (pairs = N/2).
- Q, 3329, modulus.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin operation; sampled only in S_IDLE.
- a  input  signed 32 x N  NTT-domain operand; coefficients in [0,Q-1].
- b  input  signed 32 x N  NTT-domain operand; coefficients in [0,Q-1].
- busy  output  1  high in every state except S_IDLE.
- done  output  1  one-cycle pulse when h is complete.
- h  output  signed 32 x N  product in NTT domain; coefficients in [0,Q-1].

Behaviour:
- Reset (async): state S_IDLE; h[*]=0; done=0; busy=0; pair index p=0.
  - Reset mid-operation aborts immediately. No partial result is protected.
- Twiddle ROM: gamma[i] = 17^(2*bitrev7(i)+1) mod Q, i=0..127.
  - gamma[0]=17, gamma[1]=3312, gamma[2]=2761, gamma[3]=568.
  - Constant table, 16-bit entries.
- Operand capture:
  - a and b are copied to internal registers in S_LOAD.
  - Input changes after the S_LOAD edge have no effect.
- State S_IDLE: done=0. If start=1 -> S_LOAD.
- State S_LOAD: copy operands; p<=0 -> S_PROD.
- State S_PROD: register r00=a0*b0, r11=a1*b1, r01=a0*b1, r10=a1*b0, where a0=a[2p], a1=a[2p+1] (same for b).
  - Products are < 2^24; held in 32-bit signed.
  - -> S_GAMMA.
- State S_GAMMA: t <= ((r11 % Q) * gamma[p]) % Q; s1 <= (r01 + r10) % Q -> S_WRITE.
- State S_WRITE: h[2p] <= (r00 + t) % Q; h[2p+1] <= s1.
  - If p==N/2−1: p<=0 -> S_DONE; else p<=p+1 -> S_PROD.
- State S_DONE: done=1 for exactly this one cycle -> S_IDLE unconditionally.
- Latency: start sampled at edge E0.
  - Pair k is written at edge E0+4+3k.
  - done is high in the cycle after edge E0+385 (386 edges total).
- Boundary conditions:
  - start while busy=1: ignored. No restart, no queueing.
  - start held high continuously: new run begins on the edge after the DONE cycle (S_IDLE lasts one cycle).
  - h holds its last value through S_IDLE until the next S_WRITE overwrites it.
  - Every write lands in [0,Q-1]; no negative results are produced.
  - Out-of-range inputs are outside the contract; behaviour with them is unspecified.

Optional Feature:
- Macro: NTT_BASEMUL_ACCUM_EN.
- Defined:
  - Extra input port accumulate (1 bit), captured in S_LOAD.
  - When captured 1, S_WRITE stores h[2p] <= (h[2p] + r00 + t) % Q and h[2p+1] <= (h[2p+1] + s1) % Q.
  - Accumulates the inner product of a k-element vector before the inverse NTT.
  - When captured 0, behaviour is identical to the undefined build.
- Undefined: port absent; h is always overwritten.
- Latency is unchanged in both builds.

Test Plan:
- All a=0, b=0, start pulse -> done after exactly 386 edges; h all 0; busy high from edge E0 to the DONE cycle.
- a[0]=1, a[1]=0, b[0]=5, b[1]=7, rest 0 -> h[0]=5, h[1]=7, all other h=0.
- a[0]=a[2]=0, a[1]=a[3]=1, b[1]=b[3]=1, rest 0 -> h[0]=17, h[1]=0, h[2]=3312, h[3]=0.
- All a=b=3328 -> h[1]=h[3]=…=2; h[0]=18, h[2]=3313, h[4]=2762 (i.e. 1+gamma[p] mod Q).
- Assert rst 100 cycles after start, release, then start a new run with case 2 -> during reset done=0, busy=0, h all 0; second run gives the correct result. A start pulse mid-run changes nothing.
- (NTT_BASEMUL_ACCUM_EN) Run case 2 with accumulate=0, then again with accumulate=1 -> h[0]=10, h[1]=14.
